// File: rtl/tag_array_ctrl.sv
// Controller for a 4-way two-port tag SRAM: clears every set after reset,
// then serves tag lookups and refills with victim selection.
module tag_array_ctrl #(
  parameter  int SETS  = 512,
  parameter  int WAYS  = 4,
  parameter  int TAG_W = 18,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int ENT_W = TAG_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  input  logic             refill_valid,
  output logic             refill_ready,
  input  logic [SET_W-1:0] refill_set,
  input  logic [TAG_W-1:0] refill_tag,
  output logic             refill_done,
  output logic [WAY_W-1:0] refill_way,
  output logic             init_done,
  output logic [SET_W-1:0] arr_r_addr,
  input  logic [ENT_W-1:0] arr_r_data_0,
  input  logic [ENT_W-1:0] arr_r_data_1,
  input  logic [ENT_W-1:0] arr_r_data_2,
  input  logic [ENT_W-1:0] arr_r_data_3,
  output logic             arr_w_en,
  output logic [SET_W-1:0] arr_w_addr,
  output logic [ENT_W-1:0] arr_w_data_0,
  output logic [ENT_W-1:0] arr_w_data_1,
  output logic [ENT_W-1:0] arr_w_data_2,
  output logic [ENT_W-1:0] arr_w_data_3,
  output logic [WAYS-1:0]  arr_w_maskOH
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_LOOKUP = 2'd2,
    S_RF_WR  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] init_cnt_q, init_cnt_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [SET_W-1:0] r_addr_q, r_addr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WAY_W-1:0] victim_cnt_q, victim_cnt_d;

  logic [ENT_W-1:0] rd_s [WAYS];
  logic [ENT_W-1:0] wd_s [WAYS];
  logic [WAYS-1:0]  valid_s;
  logic [WAYS-1:0]  hit_s;
  logic [WAY_W-1:0] victim_s;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [WAY_W-1:0] lowest_one(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      idx = v[i] ? WAY_W'(i) : idx;
    end
    return idx;
  endfunction

  assign rd_s[0] = arr_r_data_0;
  assign rd_s[1] = arr_r_data_1;
  assign rd_s[2] = arr_r_data_2;
  assign rd_s[3] = arr_r_data_3;

  assign arr_w_data_0 = wd_s[0];
  assign arr_w_data_1 = wd_s[1];
  assign arr_w_data_2 = wd_s[2];
  assign arr_w_data_3 = wd_s[3];

  assign arr_r_addr = r_addr_d;
  assign init_done  = (state_q != S_INIT);

  // Per-way valid and tag-match decode of the array read data.
  always_comb begin
    valid_s = '0;
    hit_s   = '0;
    for (int i = 0; i < WAYS; i++) begin
      valid_s[i] = rd_s[i][TAG_W];
      hit_s[i]   = rd_s[i][TAG_W] && (rd_s[i][TAG_W-1:0] == tag_q);
    end
  end

  // Victim: first empty way, otherwise the round-robin counter.
  always_comb begin
    if (&valid_s) begin
      victim_s = victim_cnt_q;
    end else begin
      victim_s = lowest_one(~valid_s);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    set_d        = set_q;
    tag_d        = tag_q;
    r_addr_d     = r_addr_q;
    victim_cnt_d = victim_cnt_q;
    req_ready    = 1'b0;
    refill_ready = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_way     = '0;
    refill_done  = 1'b0;
    refill_way   = '0;
    arr_w_en     = 1'b0;
    arr_w_addr   = '0;
    arr_w_maskOH = '0;
    for (int i = 0; i < WAYS; i++) begin
      wd_s[i] = '0;
    end

    case (state_q)
      S_INIT: begin
        arr_w_en     = 1'b1;
        arr_w_addr   = init_cnt_q;
        arr_w_maskOH = '1;
        init_cnt_d   = init_cnt_q + {{(SET_W-1){1'b0}}, 1'b1};
        if (init_cnt_q == SET_W'(SETS - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end

      S_IDLE: begin
        refill_ready = 1'b1;
        req_ready    = !refill_valid;
        if (refill_valid) begin
          r_addr_d = refill_set;
          set_d    = refill_set;
          tag_d    = refill_tag;
          state_d  = S_RF_WR;
        end else if (req_valid) begin
          r_addr_d = req_set;
          tag_d    = req_tag;
          state_d  = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOOKUP: begin
        resp_valid = 1'b1;
        resp_hit   = |hit_s;
        resp_way   = lowest_one(hit_s);
        req_ready  = !refill_valid;
        // A new accept here pipelines the next lookup behind this response.
        if (req_valid && !refill_valid) begin
          r_addr_d = req_set;
          tag_d    = req_tag;
          state_d  = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RF_WR: begin
        arr_w_en     = 1'b1;
        arr_w_addr   = set_q;
        arr_w_maskOH = {{(WAYS-1){1'b0}}, 1'b1} << victim_s;
        for (int i = 0; i < WAYS; i++) begin
          wd_s[i] = (WAY_W'(i) == victim_s) ? {1'b1, tag_q} : {ENT_W{1'b0}};
        end
        refill_done = 1'b1;
        refill_way  = victim_s;
        if (&valid_s) begin
          victim_cnt_d = victim_cnt_q + {{(WAY_W-1){1'b0}}, 1'b1};
        end else begin
          victim_cnt_d = victim_cnt_q;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      set_q        <= '0;
      tag_q        <= '0;
      r_addr_q     <= '0;
      victim_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      r_addr_q     <= r_addr_d;
      victim_cnt_q <= victim_cnt_d;
    end
  end

endmodule
